// File: rtl/uart_freq_report.sv
// Reports a captured frequency to the host as ASCII decimal followed by "Hz\r\n",
// one byte at a time through a byte-level UART transmitter.
module uart_freq_report #(
  parameter int unsigned VAL_W  = 17,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             report_req,
  input  logic [VAL_W-1:0] freq_val,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             report_busy,
  output logic             report_done
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned SR_W    = BCD_W + VAL_W;
  localparam int unsigned CNT_W   = $clog2(VAL_W);
  localparam int unsigned IDX_W   = $clog2(DIGITS + 4);
  localparam int unsigned LEAD_W  = $clog2(DIGITS);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEAD_W-1:0]   lead_q, lead_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                report_busy_q, report_busy_d;
  logic                report_done_q, report_done_d;

  logic [BCD_W-1:0]    bcd;
  logic [IDX_W-1:0]    ndig;
  logic [IDX_W-1:0]    pos;
  logic [IDX_W-1:0]    suffix;
  logic [3:0]          nib;
  logic [7:0]          cur_byte;
  logic                last_byte;
  logic [VAL_W-1:0]    sat_val;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (t[VAL_W + 4*i +: 4] >= 4'd5)
        t[VAL_W + 4*i +: 4] = t[VAL_W + 4*i +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Leading zero digits to skip; the least significant digit is always kept.
  function automatic logic [LEAD_W-1:0] count_lead(input logic [BCD_W-1:0] b);
    logic [LEAD_W-1:0] n;
    logic              stop;
    n    = '0;
    stop = 1'b0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (!stop && b[4*i +: 4] == 4'd0) n = n + LEAD_W'(1);
      else                              stop = 1'b1;
    end
    return n;
  endfunction

  assign sat_val = (freq_val > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : freq_val;

  // Byte currently addressed by idx_q: digits first, then the "Hz\r\n" suffix.
  always_comb begin
    bcd    = shift_q[SR_W-1 -: BCD_W];
    ndig   = IDX_W'(DIGITS) - IDX_W'(lead_q);
    pos    = IDX_W'(lead_q) + idx_q;
    suffix = idx_q - ndig;
    nib    = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (pos == IDX_W'(int'(DIGITS) - 1 - i)) nib = bcd[4*i +: 4];
    end
    if (idx_q < ndig) begin
      cur_byte = 8'h30 + {4'h0, nib};
    end else begin
      case (suffix)
        IDX_W'(0): cur_byte = 8'h48;
        IDX_W'(1): cur_byte = 8'h7A;
        IDX_W'(2): cur_byte = 8'h0D;
        default:   cur_byte = 8'h0A;
      endcase
    end
    last_byte = (idx_q == ndig + IDX_W'(3));
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    lead_d        = lead_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    report_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (report_req) begin
          shift_d = {{BCD_W{1'b0}}, sat_val};
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        shift_d = dd_step(shift_q);
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          lead_d  = count_lead(shift_d[SR_W-1 -: BCD_W]);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end
        end
      end
      S_DONE: begin
        report_done_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    report_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      lead_q        <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      report_busy_q <= 1'b0;
      report_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      lead_q        <= lead_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      report_busy_q <= report_busy_d;
      report_done_q <= report_done_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign report_busy = report_busy_q;
  assign report_done = report_done_q;

endmodule

// File: doc/uart_freq_report.md
# uart_freq_report

Transmit-side counterpart of the UART command decoder. The decoder turns received '+'/'-' bytes into target-frequency step pulses. This block reports the current frequency back to the host as ASCII text. On a request it captures a binary frequency value and converts it to decimal with a sequential double-dabble. It then streams the digits, followed by "Hz\r\n", one byte at a time into the byte-level UART transmitter.

## Interface
- VAL_W, 17, width of freq_val; fixed pairing with DIGITS.
- DIGITS, 5, number of decimal digits; the maximum reportable value is 10^DIGITS-1 = 99999.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low; clock clk.
- report_req  input  1  single-cycle request. Sampled only in IDLE; ignored otherwise.
- freq_val  input  VAL_W  unsigned frequency in Hz. Sampled only on the accepted report_req edge.
- tx_busy  input  1  from the UART TX. It goes high within 1..2 cycles of tx_start and stays high until the stop bit completes.
- tx_start  output  1  one-cycle pulse that launches a byte.
- tx_data  output  8  byte to send. Valid and held stable from the tx_start cycle until tx_busy falls.
- report_busy  output  1  high in every state except IDLE.
- report_done  output  1  one-cycle pulse when the final byte (0x0A) has finished.

## Operation
- Reset values: tx_start=0, tx_data=8'h00, report_busy=0, report_done=0, state=IDLE, all internal registers 0.
- States: IDLE, CONV, SEND, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - On report_req=1, capture freq_val into the shift register and go to CONV.
  - If freq_val > 99999, load 99999 instead (saturation).
- CONV: double-dabble, one bit per cycle, exactly VAL_W cycles. Each cycle, every BCD nibble >= 5 gets +3 before the left shift. Then go to SEND.
- Byte list built at the end of CONV:
  - Significant digits, MSD first. Leading zeros are suppressed, but at least one digit is always sent, so value 0 sends "0". Inner and trailing zeros are kept.
  - Then 0x48 'H', 0x7A 'z', 0x0D, 0x0A.
  - Digit byte = 0x30 + BCD nibble.
  - Byte count = ndigits + 4, ranging from 5 to 9.
- SEND: wait while tx_busy=1. When tx_busy=0, drive tx_data with the current byte, pulse tx_start for one cycle, and go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. There is no timeout; a TX that never asserts busy stalls the block until reset.
- WAIT_LO: wait for tx_busy=0.
  - If bytes remain, advance the byte index and go to SEND.
  - Otherwise go to DONE.
- DONE: pulse report_done for one cycle and return to IDLE.
- Timing of report_busy and report_done:
  - report_busy is already low in the report_done cycle.
  - A report_req arriving in that same cycle is sampled by IDLE on the following edge and is accepted.
- freq_val changes after capture do not affect the report in progress.
- Asserting rst_n low mid-operation:
  - Asynchronously clears every output and register. Any partial transmission is abandoned; the UART TX completes its current byte on its own.
  - Once rst_n is released, the next report_req works normally.

## Timing
- Cycle 0 is the edge that samples report_req=1 in IDLE. Cycles 1..VAL_W are CONV (17 cycles at the default). Cycle VAL_W+1 is SEND.
- The first tx_start is high during cycle VAL_W+2, provided tx_busy=0.
- If tx_busy=1 at that point, tx_start is delayed until the first cycle after tx_busy is sampled low.
- Gap between bytes: the next tx_start comes 2 cycles after the cycle in which tx_busy is sampled low.
- report_done comes 2 cycles after tx_busy falls on the last byte.
- tx_start never asserts while tx_busy=1 and never asserts twice for the same byte.

## Test plan
- freq_val=12345, TX model with busy=10 cycles -> bytes 31 32 33 34 35 48 7A 0D 0A in order. First tx_start at cycle 19. Exactly one report_done.
- freq_val=0 -> bytes 30 48 7A 0D 0A. freq_val=100 -> 31 30 30 48 7A 0D 0A (inner zeros kept).
- freq_val=131071 -> saturated output 39 39 39 39 39 48 7A 0D 0A.
- report_req pulsed again during SEND, with freq_val changed to 7 -> second request ignored. Output is still the originally captured digits. report_busy stays high until report_done.
- tx_busy held high for 40 cycles when the request is accepted -> no tx_start until tx_busy is sampled low. Then the normal sequence follows.
- rst_n pulsed low during the third byte -> tx_start, tx_data, report_busy and report_done all read 0 immediately. A subsequent request with 42 yields 34 32 48 7A 0D 0A.
